// File: rtl/axis_wait_arbiter.sv
// Round-robin frame arbiter ahead of the shared AXI-stream wait buffer.
// Grants one source for FRAME_LEN beats, then holds buf_start until it is acknowledged.
//
// state | meaning
// IDLE  | waiting for requests; arbitrates on any s_valid
// XFER  | granted source passed straight through to m_*
// START | frame complete; buf_start held until buf_start_ack
module axis_wait_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 2,
    parameter int FRAME_LEN = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]       s_valid,
    output logic [NUM_SRC-1:0]       s_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     buf_start,
    input  logic                     buf_start_ack,
    output logic [1:0]               grant_id,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, XFER, START} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last_grant;
    logic [1:0]       arb_idx;
    logic             arb_found;
    logic             beat;
    logic             last_beat;

    // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (s_valid[i] && (((int'(last_grant) + k) % NUM_SRC) == i)) begin
                    arb_found = 1'b1;
                    arb_idx   = 2'(i);
                end
            end
        end
    end

    assign beat      = (state == XFER) && m_valid && m_ready;
    assign last_beat = beat && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_found)     state_nxt = XFER;
            XFER:    if (last_beat)     state_nxt = START;
            START:   if (buf_start_ack) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            grant_id   <= '0;
            last_grant <= 2'(NUM_SRC - 1);
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == START) && buf_start_ack;
            if (state == IDLE && arb_found) begin
                grant_id <= arb_idx;
            end
            if (state == START && buf_start_ack) begin
                last_grant <= grant_id;
            end
            if (beat) begin
                cnt <= last_beat ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        m_data    = '0;
        m_valid   = 1'b0;
        s_ready   = '0;
        buf_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            XFER: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_id == 2'(i)) begin
                        m_data     = s_data[i*WIDTH +: WIDTH];
                        m_valid    = s_valid[i];
                        s_ready[i] = m_ready;
                    end
                end
            end
            START:   buf_start = 1'b1;
            default: ;
        endcase
    end

endmodule
